// File: rtl/sw_pwm_pkg.sv
// sw_pwm shared defaults and helpers.
// Counter width derives from the PWM period.
package sw_pwm_pkg;

   localparam int DATA_W_DEF  = 16;
   localparam int PERIOD_DEF  = 100_000_000;
   localparam int ON_TIME_DEF = 50_000_000;

   function automatic int cnt_w(input int period);
      return (period > 1) ? $clog2(period) : 1;
   endfunction

endpackage

// File: rtl/sw_pwm_timebase.sv
// Free-running period counter for sw_pwm.
// Wraps from PERIOD-1 to 0 and flags the wrap cycle.
module pwm_timebase
   import sw_pwm_pkg::*;
#(
   parameter int PERIOD = PERIOD_DEF,
   localparam int CW = cnt_w(PERIOD)
) (
   input  logic          clk,
   input  logic          rst,
   output logic [CW-1:0] count,
   output logic          wrap
);

   localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

   logic [CW-1:0] sec_counter;

   assign wrap  = (sec_counter == LAST);
   assign count = sec_counter;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sec_counter <= '0;
      else if (wrap)
         sec_counter <= '0;
      else
         sec_counter <= sec_counter + CW'(1);
   end

endmodule

// File: rtl/sw_pwm.sv
// Gates a switch pattern onto the LEDs during the
// first ON_TIME cycles of every PERIOD-cycle window.
module sw_pwm
   import sw_pwm_pkg::*;
#(
   parameter int ON_TIME = ON_TIME_DEF,
   parameter int PERIOD  = PERIOD_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] sw,
   output logic [DATA_W-1:0] led
);

   localparam int CW = cnt_w(PERIOD);
   localparam logic [63:0] ON_U = 64'(ON_TIME);

   if (PERIOD < 1) begin : g_bad_period
      $fatal(1, "sw_pwm: PERIOD must be >= 1");
   end
   if (ON_TIME < 0) begin : g_bad_on
      $fatal(1, "sw_pwm: ON_TIME must be >= 0");
   end

   logic [CW-1:0] sec_counter;
   logic          unused_wrap;
   logic          on_win;

   pwm_timebase #(
      .PERIOD (PERIOD)
   ) u_timebase (
      .clk   (clk),
      .rst   (rst),
      .count (sec_counter),
      .wrap  (unused_wrap)
   );

   // 64-bit compare so ON_TIME >= PERIOD never truncates
   assign on_win = (64'(sec_counter) < ON_U);
   assign led    = (on_win && !rst) ? sw : '0;

endmodule

// File: tb/tb_sw_pwm.sv
// Directed self-checking bench for sw_pwm.
// Four instances cover on/off windows, edge parameters and defaults.
module tb_sw_pwm;

   typedef struct {
      logic [15:0] sw;
      int          cnt;
      logic [15:0] led;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_a = 1'b1, rst_b = 1'b1;
   logic        rst_c = 1'b1, rst_d = 1'b1;
   logic [15:0] sw_a = '0, sw_b = '0, sw_c = '0, sw_d = '0;
   logic [15:0] led_a, led_b, led_c, led_d;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sw_pwm #(.ON_TIME(5), .PERIOD(20), .DATA_W(16)) dut_a (
      .clk(clk), .rst(rst_a), .sw(sw_a), .led(led_a));
   sw_pwm #(.ON_TIME(0), .PERIOD(8), .DATA_W(16)) dut_b (
      .clk(clk), .rst(rst_b), .sw(sw_b), .led(led_b));
   sw_pwm #(.ON_TIME(8), .PERIOD(8), .DATA_W(16)) dut_c (
      .clk(clk), .rst(rst_c), .sw(sw_c), .led(led_c));
   sw_pwm dut_d (
      .clk(clk), .rst(rst_d), .sw(sw_d), .led(led_d));

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   vec_t tab[22];

   initial begin
      // on-window 0..4, sw swapped at cnt 2 and 10, then wrap
      for (int i = 0; i < 22; i++) begin
         tab[i].cnt = i % 20;
         tab[i].sw  = (i >= 2 && i < 10) ? 16'h5A5A : 16'hA5A5;
         tab[i].led = (tab[i].cnt < 5) ? tab[i].sw : 16'h0000;
      end

      // reset state
      sw_a = 16'hFFFF;
      @(negedge clk);
      chk("rst_led_a", 64'(led_a), 64'h0);
      chk("rst_cnt_a", 64'(dut_a.sec_counter), 64'd0);
      rst_a = 1'b0;

      for (int i = 0; i < 22; i++) begin
         sw_a = tab[i].sw;
         #1;
         chk($sformatf("tab_led_%0d", i), 64'(led_a), 64'(tab[i].led));
         chk($sformatf("tab_cnt_%0d", i),
             64'(dut_a.sec_counter), 64'(tab[i].cnt));
         @(negedge clk);
      end

      // mid-period async reset at cnt 12
      sw_a = 16'hA5A5;
      repeat (10) @(negedge clk);
      chk("pre_rst_cnt", 64'(dut_a.sec_counter), 64'd12);
      chk("pre_rst_led", 64'(led_a), 64'h0);
      #1 rst_a = 1'b1;
      #1;
      chk("async_cnt", 64'(dut_a.sec_counter), 64'd0);
      chk("async_led", 64'(led_a), 64'h0);
      #1 rst_a = 1'b0;
      #1;
      chk("rel_led", 64'(led_a), 64'hA5A5);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk($sformatf("post_cnt_%0d", k),
             64'(dut_a.sec_counter), 64'(k));
         chk($sformatf("post_led_%0d", k), 64'(led_a),
             (k < 5) ? 64'hA5A5 : 64'h0);
      end

      // ON_TIME = 0: never lit
      sw_b = 16'hFFFF;
      rst_b = 1'b0;
      for (int i = 0; i < 24; i++) begin
         #1;
         chk($sformatf("zero_led_%0d", i), 64'(led_b), 64'h0);
         @(negedge clk);
      end

      // ON_TIME = PERIOD: always lit, across wraps
      sw_c = 16'h1234;
      rst_c = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #1;
         chk($sformatf("full_led_%0d", i), 64'(led_c), 64'h1234);
         chk($sformatf("full_cnt_%0d", i),
             64'(dut_c.sec_counter), 64'(i % 8));
         @(negedge clk);
      end

      // default parameters
      sw_d = 16'hBEEF;
      rst_d = 1'b0;
      repeat (1000) @(posedge clk);
      #1;
      chk("dflt_cnt", 64'(dut_d.sec_counter), 64'd1000);
      chk("dflt_led", 64'(led_d), 64'hBEEF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
